rx_frame_tracker: RTL

Sequential framing tracker for the RX data-stream path. Consumes one DW (four symbols) per valid beat and decodes the token at each token boundary (STP, SDP, IDL, EDS). It tracks TLP/DLLP extent with a DW counter, marks start and end of packet on a registered output stream, and detects framing errors. After a framing error or an EDS it waits for the next start-of-data-stream indication. It sits directly after lane deskew/descrambling and feeds the TLP/DLLP buffers.

---
 rtl/rx_frame_if.sv | 30 +++
 rtl/rx_frame_tracker.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/rx_frame_if.sv
// RX framing stream bundle: deskewed DW beats in, framed packet beats and error status out.
interface rx_frame_if #(
  parameter int SYMBOL_WIDTH  = 8,
  parameter int ERR_CNT_WIDTH = 8
);
  logic                       i_sds;
  logic                       i_valid;
  logic [0:4*SYMBOL_WIDTH-1]  i_data;
  logic                       o_valid;
  logic [0:4*SYMBOL_WIDTH-1]  o_data;
  logic                       o_type;
  logic                       o_sop;
  logic                       o_eop;
  logic                       o_frame_err;
  logic [2:0]                 o_err_code;
  logic [ERR_CNT_WIDTH-1:0]   o_err_cnt;
  logic                       o_eds_seen;

  modport master (
    output i_sds, i_valid, i_data,
    input  o_valid, o_data, o_type, o_sop, o_eop,
           o_frame_err, o_err_code, o_err_cnt, o_eds_seen
  );

  modport slave (
    input  i_sds, i_valid, i_data,
    output o_valid, o_data, o_type, o_sop, o_eop,
           o_frame_err, o_err_code, o_err_cnt, o_eds_seen
  );
endinterface

// File: rtl/rx_frame_tracker.sv
// Token-boundary framing tracker: decodes STP/SDP/IDL/EDS, tracks TLP extent, flags framing errors.
module rx_frame_tracker #(
  parameter int SYMBOL_WIDTH  = 8,
  parameter int LEN_WIDTH     = 11,
  parameter int MIN_TLP_DW    = 5,
  parameter int MAX_TLP_DW    = 1031,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  rx_frame_if.slave   bus
);
  typedef enum logic [1:0] {WAIT_SDS, SCAN, TLP, DLLP} state_t;

  localparam logic [2:0] ERR_TOKEN = 3'd1;
  localparam logic [2:0] ERR_CRC   = 3'd2;
  localparam logic [2:0] ERR_LEN   = 3'd3;
  localparam logic [2:0] ERR_TRUNC = 3'd4;

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] rem, rem_nxt;

  logic [SYMBOL_WIDTH-1:0] s0, s1, s2, s3;
  assign s0 = bus.i_data[0*SYMBOL_WIDTH +: SYMBOL_WIDTH];
  assign s1 = bus.i_data[1*SYMBOL_WIDTH +: SYMBOL_WIDTH];
  assign s2 = bus.i_data[2*SYMBOL_WIDTH +: SYMBOL_WIDTH];
  assign s3 = bus.i_data[3*SYMBOL_WIDTH +: SYMBOL_WIDTH];

  logic [10:0] stp_len;
  logic [3:0]  calc;
  logic        is_stp, is_sdp, is_idl, is_eds, crc_ok, len_ok;

  assign stp_len = {s1[6:0], s0[7:4]};
  assign calc[0] = stp_len[0] ^ stp_len[1] ^ stp_len[2] ^ stp_len[4] ^ stp_len[6] ^ stp_len[7] ^ stp_len[10];
  assign calc[1] = stp_len[2] ^ stp_len[3] ^ stp_len[4] ^ stp_len[5] ^ stp_len[7] ^ stp_len[9] ^ stp_len[10];
  assign calc[2] = stp_len[1] ^ stp_len[2] ^ stp_len[3] ^ stp_len[4] ^ stp_len[6] ^ stp_len[8] ^ stp_len[9];
  assign calc[3] = stp_len[0] ^ stp_len[1] ^ stp_len[2] ^ stp_len[3] ^ stp_len[5] ^ stp_len[7] ^ stp_len[8];
  assign crc_ok  = (s2[7:4] == calc) && (s1[7] == ((^stp_len) ^ (^calc)));
  assign len_ok  = (int'(stp_len) >= MIN_TLP_DW) && (int'(stp_len) <= MAX_TLP_DW);

  // EDS also carries a 4'hF low nibble in s0, so it must win over the STP header match.
  assign is_eds = (s0 == 8'h1F) && (s1 == 8'h80) && (s2 == 8'h90) && (s3 == 8'h00);
  assign is_sdp = (s0 == 8'hF0) && (s1 == 8'hAC);
  assign is_idl = (s0 == 8'h00) && (s1 == 8'h00) && (s2 == 8'h00) && (s3 == 8'h00);
  assign is_stp = (s0[3:0] == 4'hF);

  logic       valid_nxt, type_nxt, sop_nxt, eop_nxt, err_nxt, eds_nxt;
  logic [2:0] code_nxt;

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    valid_nxt = 1'b0;
    type_nxt  = 1'b0;
    sop_nxt   = 1'b0;
    eop_nxt   = 1'b0;
    err_nxt   = 1'b0;
    eds_nxt   = 1'b0;
    code_nxt  = bus.o_err_code;
    unique case (state)
      WAIT_SDS: if (bus.i_sds) state_nxt = SCAN;
      SCAN: begin
        // A concurrent i_sds discards the beat; otherwise it is a no-op here.
        if (!bus.i_sds && bus.i_valid) begin
          if (is_eds) begin
            eds_nxt   = 1'b1;
            state_nxt = WAIT_SDS;
          end else if (is_sdp) begin
            valid_nxt = 1'b1;
            type_nxt  = 1'b1;
            sop_nxt   = 1'b1;
            state_nxt = DLLP;
          end else if (is_stp) begin
            if (!crc_ok) begin
              err_nxt  = 1'b1;
              code_nxt = ERR_CRC;
            end else if (!len_ok) begin
              err_nxt  = 1'b1;
              code_nxt = ERR_LEN;
            end else begin
              valid_nxt = 1'b1;
              sop_nxt   = 1'b1;
              rem_nxt   = LEN_WIDTH'(stp_len - 11'd1);
              state_nxt = TLP;
            end
          end else if (!is_idl) begin
            err_nxt  = 1'b1;
            code_nxt = ERR_TOKEN;
          end
          if (err_nxt) state_nxt = WAIT_SDS;
        end
      end
      TLP, DLLP: begin
        type_nxt = (state == DLLP);
        if (bus.i_sds) begin
          // Truncated packet: close it with a data-less eop and resume scanning.
          err_nxt   = 1'b1;
          code_nxt  = ERR_TRUNC;
          eop_nxt   = 1'b1;
          state_nxt = SCAN;
        end else if (bus.i_valid) begin
          valid_nxt = 1'b1;
          if (state == DLLP) begin
            eop_nxt   = 1'b1;
            state_nxt = SCAN;
          end else begin
            rem_nxt = rem - LEN_WIDTH'(1);
            if (rem == LEN_WIDTH'(1)) begin
              eop_nxt   = 1'b1;
              state_nxt = SCAN;
            end
          end
        end
      end
      default: state_nxt = WAIT_SDS;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= WAIT_SDS;
      rem             <= '0;
      bus.o_valid     <= 1'b0;
      bus.o_data      <= '0;
      bus.o_type      <= 1'b0;
      bus.o_sop       <= 1'b0;
      bus.o_eop       <= 1'b0;
      bus.o_frame_err <= 1'b0;
      bus.o_err_code  <= '0;
      bus.o_err_cnt   <= '0;
      bus.o_eds_seen  <= 1'b0;
    end else begin
      state           <= state_nxt;
      rem             <= rem_nxt;
      bus.o_valid     <= valid_nxt;
      bus.o_type      <= type_nxt;
      bus.o_sop       <= sop_nxt;
      bus.o_eop       <= eop_nxt;
      bus.o_frame_err <= err_nxt;
      bus.o_err_code  <= code_nxt;
      bus.o_eds_seen  <= eds_nxt;
      if (bus.i_valid) bus.o_data <= bus.i_data;
      if (err_nxt && !(&bus.o_err_cnt)) bus.o_err_cnt <= bus.o_err_cnt + ERR_CNT_WIDTH'(1);
    end
  end
endmodule
